ca_pair_match_queue: RTL and testbench
======================================

Name: ca_pair_match_queue

Overview:
- Pairing stage that feeds the CA field comparator in the RCD scoreboard path.
- Buffers expected CA packets from the reference model in order, pairs each with the next observed DUT CA packet, and performs a registered field-by-field compare.
- Handles orphans (DUT packet with no expectation) and timeouts (an expectation never answered), and keeps saturating pass/fail/timeout/orphan statistics for end-of-test checks.

Parameters:
DEPTH, 8, expected-packet FIFO depth (power of 2, >=2)
TIMEOUT_CYC, 64, cycles a head entry may wait before being retired as timed out (>=2)
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  clock
rst_n  in  1  reset
exp_valid  in  1  expected packet valid
exp_ready  out  1  expected packet accepted when high with exp_valid
exp_pkt  in  30  {ca[9:0], cs_n, cid[2:0], bcw[5:0], dca[7:0]}, MSB first
act_valid  in  1  observed DUT packet; always accepted, no ready
act_pkt  in  30  same packing as exp_pkt
flush  in  1  discard all queued expectations
clear_stats  in  1  zero all statistics counters
cmp_valid  out  1  one-cycle pulse, compare result valid
cmp_all_match  out  1  all five fields equal
cmp_mismatch_mask  out  5  bit0 CA, bit1 CS_n, bit2 CID, bit3 BCW, bit4 DCA; 1 = mismatch
cmp_match_count  out  3  number of equal fields, 0..5
timeout_pulse  out  1  one-cycle pulse, head entry retired by timeout
orphan_pulse  out  1  one-cycle pulse, act packet arrived with queue empty
level  out  $clog2(DEPTH)+1  queued expectations
pass_cnt, fail_cnt, timeout_cnt, orphan_cnt  out  CNT_W each  saturating statistics

Behaviour:
- Interface decision: one clock, `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset values: all outputs 0 except exp_ready, which is 1 while out of reset. FIFO empty, age counter 0, FSM in EMPTY.
- exp_ready = (level != DEPTH). It is combinational from registered state only.
  - A push when full is not possible.
  - A pop in the same cycle does not raise ready.
- FSM states:
  - EMPTY (level==0): age held at 0.
  - WAIT (level>0): age increments every cycle the head is not popped.
  - EMPTY->WAIT on push.
  - WAIT->EMPTY when a pop leaves level==0 with no push in that cycle.
- act_valid in WAIT: pop head, compare head vs act_pkt. Results are registered: cmp_* are valid the cycle after act_valid (latency 1). Age resets to 0.
- act_valid in EMPTY:
  - orphan_pulse next cycle; orphan_cnt+1; packet dropped.
  - A same-cycle exp push does NOT pair with it (no bypass).
- Timeout: in WAIT, when age reaches TIMEOUT_CYC-1 with no act_valid that cycle:
  - pop head; timeout_pulse next cycle; timeout_cnt+1; age reset to 0.
  - An act_valid in that same cycle takes priority: normal compare, no timeout.
- Simultaneous push and pop: level unchanged. Push and pop pointers each wrap modulo DEPTH.
- Compare rules:
  - Each field is equal iff its bits are equal.
  - all_match = AND of all five field-equal flags.
  - match_count = popcount of the field-equal flags.
  - mismatch_mask = inverse of the field-equal flags.
  - cmp_valid with all_match increments pass_cnt; otherwise it increments fail_cnt.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clear_stats zeroes all four counters next cycle. If an increment lands in the same cycle, clear wins.
- flush (synchronous):
  - Empties the FIFO, sets age to 0, FSM to EMPTY.
  - In the same cycle, flush overrides any pop, timeout or push; the pushed packet is dropped even though exp_ready was high.
  - act_valid in the flush cycle is treated as an orphan.
  - Counters are untouched by flush.
- Reset mid-operation: everything returns to reset values immediately. No pulse is emitted for discarded entries.

Test Plan:
- Push exp 0x0ABCDEF5 then act 0x0ABCDEF5 two cycles later -> cmp_valid one cycle after act, all_match=1, mask=00000, match_count=5, pass_cnt=1, level 1->0.
- Push exp with cid=3'd2; act identical except cid=3'd5 and dca flipped -> mask=00100|10000=5'b10100, match_count=3, fail_cnt=1.
- Push DEPTH=8 entries with act idle -> exp_ready=0 at level 8. Then act_valid and exp_valid together -> pop only, level 7, exp_ready=1 next cycle.
- Push one exp, no act for 64 cycles -> timeout_pulse at cycle 64 after push, timeout_cnt=1, level=0. Repeat with act at age 63 -> compare, no timeout.
- act_valid with queue empty, plus a same-cycle exp push -> orphan_pulse=1, orphan_cnt=1, level=1 afterwards.
- Preload orphan_cnt near saturation (CNT_W=4, 16 orphans) -> holds at 15. Then clear_stats together with an orphan -> all counters 0. Then flush with 3 queued entries -> level 0, no pulses.

Source files
------------

// File: rtl/ca_pair_match_queue.sv
// ca_pair_match_queue
// Queues expected CA packets in arrival order and pairs the oldest one with
// the next observed DUT packet. The fields are compared and the result is
// registered. Expectations that wait too long are retired as timeouts.
// Observed packets that arrive with nothing queued are counted as orphans.
//
// Packet layout, low 28 bits; bits [29:28] are padding and are not compared:
//   [27:18] ca, [17] cs_n, [16:14] cid, [13:8] bcw, [7:0] dca
//
// Handshake: an expected packet is accepted on a clock edge when exp_valid
// and exp_ready are both high and flush is low. exp_ready depends only on
// registered state. act_valid has no ready and is always consumed.
module ca_pair_match_queue #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     exp_valid,
    output logic                     exp_ready,
    input  logic [29:0]              exp_pkt,
    input  logic                     act_valid,
    input  logic [29:0]              act_pkt,
    input  logic                     flush,
    input  logic                     clear_stats,
    output logic                     cmp_valid,
    output logic                     cmp_all_match,
    output logic [4:0]               cmp_mismatch_mask,
    output logic [2:0]               cmp_match_count,
    output logic                     timeout_pulse,
    output logic                     orphan_pulse,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic [CNT_W-1:0]         timeout_cnt,
    output logic [CNT_W-1:0]         orphan_cnt,
    output logic                     dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int AW = $clog2(TIMEOUT_CYC);
    localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT_CYC - 1);
    localparam logic [PW:0]   LVL_FULL = (PW + 1)'(DEPTH);

    typedef enum logic {S_EMPTY = 1'b0, S_WAIT = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   age_q, age_d;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [27:0]     mem [DEPTH];
    logic [27:0]     head;
    logic            push, pop_act, pop_to, orphan;
    logic [4:0]      eq;
    logic [2:0]      eq_cnt;
    logic            unused_pad;

    assign unused_pad = ^{exp_pkt[29:28], act_pkt[29:28]};
    assign exp_ready  = (level != LVL_FULL);
    assign push       = exp_valid && exp_ready && !flush;
    assign head       = mem[rd_ptr];
    assign dbg_state  = state_q;

    // Field equality between the queue head and the observed packet
    always_comb begin
        eq[0]  = (head[27:18] == act_pkt[27:18]);
        eq[1]  = (head[17]    == act_pkt[17]);
        eq[2]  = (head[16:14] == act_pkt[16:14]);
        eq[3]  = (head[13:8]  == act_pkt[13:8]);
        eq[4]  = (head[7:0]   == act_pkt[7:0]);
        eq_cnt = {2'b00, eq[0]} + {2'b00, eq[1]} + {2'b00, eq[2]}
               + {2'b00, eq[3]} + {2'b00, eq[4]};
    end

    // Next-state: pairing, timeout retirement, orphan detection, age
    always_comb begin
        state_d = state_q;
        age_d   = age_q;
        pop_act = 1'b0;
        pop_to  = 1'b0;
        orphan  = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
            age_d   = '0;
            orphan  = act_valid;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    age_d  = '0;
                    orphan = act_valid;
                    if (push) state_d = S_WAIT;
                end
                S_WAIT: begin
                    // An arriving packet beats a timeout in the same cycle
                    if (act_valid)            pop_act = 1'b1;
                    else if (age_q == AGE_MAX) pop_to = 1'b1;
                    if (pop_act || pop_to) begin
                        age_d = '0;
                        if (level == (PW + 1)'(1) && !push) state_d = S_EMPTY;
                    end else begin
                        age_d = age_q + 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // State, age, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            age_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
        end else begin
            state_q <= state_d;
            age_q   <= age_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop_act || pop_to) rd_ptr <= rd_ptr + 1'b1;
                level <= level + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop_act || pop_to};
            end
        end
    end

    // Expectation storage; contents need no reset because level gates use
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= exp_pkt[27:0];
    end

    // Registered compare result and event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_valid         <= 1'b0;
            cmp_all_match     <= 1'b0;
            cmp_mismatch_mask <= '0;
            cmp_match_count   <= '0;
            timeout_pulse     <= 1'b0;
            orphan_pulse      <= 1'b0;
        end else begin
            cmp_valid     <= pop_act;
            timeout_pulse <= pop_to;
            orphan_pulse  <= orphan;
            if (pop_act) begin
                cmp_all_match     <= &eq;
                cmp_mismatch_mask <= ~eq;
                cmp_match_count   <= eq_cnt;
            end
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Saturating statistics; a clear beats an increment in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_cnt <= '0;
            orphan_cnt  <= '0;
        end else if (clear_stats) begin
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_cnt <= '0;
            orphan_cnt  <= '0;
        end else begin
            if (pop_act && (&eq))  pass_cnt    <= sat_inc(pass_cnt);
            if (pop_act && !(&eq)) fail_cnt    <= sat_inc(fail_cnt);
            if (pop_to)            timeout_cnt <= sat_inc(timeout_cnt);
            if (orphan)            orphan_cnt  <= sat_inc(orphan_cnt);
        end
    end
endmodule

// File: tb/tb_ca_pair_match_queue.sv
// Directed bench for ca_pair_match_queue. It uses DEPTH=8, TIMEOUT_CYC=64
// and CNT_W=4, so that counter saturation can be reached quickly.
module tb_ca_pair_match_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        exp_valid, act_valid, flush, clear_stats;
    logic        exp_ready;
    logic [29:0] exp_pkt, act_pkt;
    logic        cmp_valid, cmp_all_match, timeout_pulse, orphan_pulse, dbg_state;
    logic [4:0]  cmp_mismatch_mask;
    logic [2:0]  cmp_match_count;
    logic [3:0]  level;
    logic [3:0]  pass_cnt, fail_cnt, timeout_cnt, orphan_cnt;

    int checks = 0;
    int errors = 0;

    ca_pair_match_queue #(.DEPTH(8), .TIMEOUT_CYC(64), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_pkt(exp_pkt),
        .act_valid(act_valid), .act_pkt(act_pkt),
        .flush(flush), .clear_stats(clear_stats),
        .cmp_valid(cmp_valid), .cmp_all_match(cmp_all_match),
        .cmp_mismatch_mask(cmp_mismatch_mask), .cmp_match_count(cmp_match_count),
        .timeout_pulse(timeout_pulse), .orphan_pulse(orphan_pulse),
        .level(level), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .timeout_cnt(timeout_cnt), .orphan_cnt(orphan_cnt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    localparam logic [29:0] BASE = 30'h0123_4560;

    initial begin
        logic [29:0] e2, a2;
        logic        seen;
        rst_n = 1'b0; exp_valid = 1'b0; act_valid = 1'b0; flush = 1'b0;
        clear_stats = 1'b0; exp_pkt = '0; act_pkt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_cmp_valid", cmp_valid, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        step();
        chk("rst_exp_ready", exp_ready, 1);
        chk("rst_orphan", orphan_pulse, 0);

        // Matching pair
        exp_valid = 1'b1; exp_pkt = 30'h0ABCDEF5;
        step();
        exp_valid = 1'b0;
        chk("t1_level_push", level, 1);
        chk("t1_state_wait", dbg_state, 1);
        step();
        chk("t1_no_early_cmp", cmp_valid, 0);
        act_valid = 1'b1; act_pkt = 30'h0ABCDEF5;
        step();
        act_valid = 1'b0;
        chk("t1_cmp_valid", cmp_valid, 1);
        chk("t1_all_match", cmp_all_match, 1);
        chk("t1_mask", cmp_mismatch_mask, 5'b00000);
        chk("t1_count", cmp_match_count, 5);
        chk("t1_pass_cnt", pass_cnt, 1);
        chk("t1_level_pop", level, 0);
        step();
        chk("t1_cmp_pulse_end", cmp_valid, 0);

        // cid and dca differ
        e2 = {2'b00, 10'h155, 1'b1, 3'd2, 6'h2A, 8'h3C};
        a2 = {2'b00, 10'h155, 1'b1, 3'd5, 6'h2A, 8'hC3};
        exp_valid = 1'b1; exp_pkt = e2;
        step();
        exp_valid = 1'b0; act_valid = 1'b1; act_pkt = a2;
        step();
        act_valid = 1'b0;
        chk("t2_cmp_valid", cmp_valid, 1);
        chk("t2_all_match", cmp_all_match, 0);
        chk("t2_mask", cmp_mismatch_mask, 5'b10100);
        chk("t2_count", cmp_match_count, 3);
        chk("t2_fail_cnt", fail_cnt, 1);
        chk("t2_pass_cnt", pass_cnt, 1);

        // Fill to DEPTH, then pop with a blocked push, then drain in order
        exp_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_pkt = BASE + 30'(i);
            step();
        end
        chk("t3_level_full", level, 8);
        chk("t3_ready_low", exp_ready, 0);
        exp_pkt = 30'h3FFFFFF; act_valid = 1'b1; act_pkt = BASE;
        step();
        exp_valid = 1'b0;
        chk("t3_level_7", level, 7);
        chk("t3_ready_high", exp_ready, 1);
        chk("t3_head_match", cmp_all_match, 1);
        for (int i = 1; i < 8; i++) begin
            act_pkt = BASE + 30'(i);
            step();
            chk($sformatf("t3_drain_%0d", i), {cmp_valid, cmp_all_match}, 2'b11);
        end
        act_valid = 1'b0;
        chk("t3_level_empty", level, 0);
        chk("t3_pass_cnt", pass_cnt, 9);

        // Timeout after 64 cycles
        exp_valid = 1'b1; exp_pkt = 30'h0000_1234;
        step();
        exp_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 63; i++) begin
            step();
            seen = seen | timeout_pulse;
        end
        chk("t4_no_early_timeout", seen, 0);
        chk("t4_level_before", level, 1);
        step();
        chk("t4_timeout_pulse", timeout_pulse, 1);
        chk("t4_timeout_cnt", timeout_cnt, 1);
        chk("t4_level_after", level, 0);
        step();
        chk("t4_pulse_end", timeout_pulse, 0);

        // Answer arrives exactly at age 63: compare wins over timeout
        exp_valid = 1'b1; exp_pkt = 30'h0000_5678;
        step();
        exp_valid = 1'b0;
        repeat (63) step();
        act_valid = 1'b1; act_pkt = 30'h0000_5678;
        step();
        act_valid = 1'b0;
        chk("t4b_cmp_valid", cmp_valid, 1);
        chk("t4b_no_timeout", timeout_pulse, 0);
        chk("t4b_timeout_cnt", timeout_cnt, 1);
        chk("t4b_pass_cnt", pass_cnt, 10);

        // Orphan with a same-cycle push: no bypass
        act_valid = 1'b1; act_pkt = 30'h0000_0001;
        exp_valid = 1'b1; exp_pkt = 30'h0000_0001;
        step();
        exp_valid = 1'b0; act_valid = 1'b0;
        chk("t5_orphan_pulse", orphan_pulse, 1);
        chk("t5_orphan_cnt", orphan_cnt, 1);
        chk("t5_level", level, 1);
        chk("t5_no_cmp", cmp_valid, 0);
        // A flush cycle with act_valid counts the act packet as an orphan
        flush = 1'b1; act_valid = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_flush_level", level, 0);
        chk("t5_flush_orphan", orphan_pulse, 1);
        chk("t5_flush_no_cmp", cmp_valid, 0);

        // Saturation: 14 more orphans, 16 in total, hold at 15
        for (int i = 0; i < 14; i++) step();
        chk("t6_sat_15", orphan_cnt, 15);
        step();
        chk("t6_sat_hold", orphan_cnt, 15);
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0; act_valid = 1'b0;
        chk("t6_clr_orphan", orphan_cnt, 0);
        chk("t6_clr_pass", pass_cnt, 0);
        chk("t6_clr_fail", fail_cnt, 0);
        chk("t6_clr_timeout", timeout_cnt, 0);

        // Flush with 3 queued entries and a same-cycle push
        exp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pkt = BASE + 30'(i);
            step();
        end
        chk("t7_level_3", level, 3);
        flush = 1'b1;
        step();
        flush = 1'b0; exp_valid = 1'b0;
        chk("t7_level_0", level, 0);
        chk("t7_no_pulses", {cmp_valid, timeout_pulse, orphan_pulse}, 3'b000);
        chk("t7_state_empty", dbg_state, 0);
        act_valid = 1'b1; act_pkt = BASE;
        step();
        act_valid = 1'b0;
        chk("t7_post_flush_orphan", orphan_pulse, 1);
        chk("t7_orphan_cnt", orphan_cnt, 1);

        // Asynchronous reset with entries queued
        exp_valid = 1'b1; exp_pkt = 30'h0000_00AA;
        step(); step();
        exp_valid = 1'b0;
        chk("t8_level_2", level, 2);
        rst_n = 1'b0;
        #1;
        chk("t8_async_level", level, 0);
        chk("t8_async_orphan_cnt", orphan_cnt, 0);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            step();
            seen = seen | timeout_pulse | cmp_valid | orphan_pulse;
        end
        chk("t8_no_pulse_after_reset", seen, 0);
        chk("t8_timeout_cnt", timeout_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
